// File: rtl/regfile_pkg.sv
// Register-file package: default geometry, shared word/address types and the
// hardwired-zero register index.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned DEPTH_DEF = 32;
    localparam int unsigned NREAD_DEF = 2;
    localparam int unsigned AW_DEF    = $clog2(DEPTH_DEF);

    typedef logic [XLEN_DEF-1:0] xword_t;
    typedef logic [AW_DEF-1:0]   raddr_t;

    localparam raddr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_multiport_sb_if.sv
// Decode/writeback bus of the register file: packed read ports, writeback port,
// issue port and the scoreboard outputs. The master is the pipeline side; the
// slave is the register file.
interface regfile_multiport_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned NREAD = NREAD_DEF
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [NREAD*AW-1:0]   RADDR;
    logic [NREAD*XLEN-1:0] RDATA;
    logic [NREAD-1:0]      RBUSY;
    logic                  WE;
    logic [AW-1:0]         WADDR;
    logic [XLEN-1:0]       WDATA;
    logic                  ISSUE_VALID;
    logic [AW-1:0]         ISSUE_RD;
    logic [AW:0]           PENDING_CNT;

    modport master (
        output RADDR,
        output WE,
        output WADDR,
        output WDATA,
        output ISSUE_VALID,
        output ISSUE_RD,
        input  RDATA,
        input  RBUSY,
        input  PENDING_CNT
    );

    modport slave (
        input  RADDR,
        input  WE,
        input  WADDR,
        input  WDATA,
        input  ISSUE_VALID,
        input  ISSUE_RD,
        output RDATA,
        output RBUSY,
        output PENDING_CNT
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register with an issued but not yet written
// back producer, plus a registered count of busy registers. Register 0 is
// never busy. An issue and a writeback to the same register in one cycle leave
// it busy (the new producer takes over).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             issue_valid_i,
    input  logic [AW-1:0]    issue_rd_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    output logic [DEPTH-1:0] busy_o,
    output logic [AW:0]      pending_cnt_o
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] set_vec, clr_vec;
    logic [AW:0]      cnt_q, cnt_d;
    logic             set_any, clr_any;
    logic             inc, dec;

    // Decode issue and writeback into one-hot set/clear vectors; x0 is excluded.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        set_any = issue_valid_i && (issue_rd_i != AW'(ZERO_REG));
        clr_any = we_i && (waddr_i != AW'(ZERO_REG));
        if (set_any) begin
            set_vec[issue_rd_i] = 1'b1;
        end
        if (clr_any) begin
            clr_vec[waddr_i] = 1'b1;
        end
    end

    // Next busy vector (set beats clear) and the matching count adjustment.
    always_comb begin
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
        // Count only real transitions: set of an idle bit, clear of a busy bit
        // that is not simultaneously re-set.
        inc   = set_any && !busy_q[issue_rd_i];
        dec   = |(clr_vec & busy_q & ~set_vec);
        cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
    end

    // Scoreboard state registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o        = busy_q;
    assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_multiport_sb.sv
// Integer register file with NREAD combinational read ports, one synchronous
// write port and a built-in scoreboard used by decode for stall decisions.
// Register 0 reads as zero and is never busy.
// Build option: define REGFILE_BYPASS_EN for write-first forwarding of the
// writeback port onto matching read ports (data and busy) in the same cycle.
module regfile_multiport_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned NREAD = NREAD_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    regfile_multiport_sb_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [XLEN-1:0]  mem_d [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             wr_en;

    assign wr_en = bus.WE && (bus.WADDR != AW'(ZERO_REG));

    // Next storage contents: a single writeback, writes to x0 dropped.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[bus.WADDR] = bus.WDATA;
        end
    end

    // Storage array, cleared by the asynchronous reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .issue_valid_i (bus.ISSUE_VALID),
        .issue_rd_i    (bus.ISSUE_RD),
        .we_i          (bus.WE),
        .waddr_i       (bus.WADDR),
        .busy_o        (busy),
        .pending_cnt_o (bus.PENDING_CNT)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rport
        logic [AW-1:0]   raddr;
        logic            is_zero;
        logic [XLEN-1:0] rdata;
        logic            rbusy;

        assign raddr   = bus.RADDR[i*AW +: AW];
        assign is_zero = (raddr == AW'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
        logic fwd;

        // Writeback to the same register is visible this cycle; busy stays
        // set only if a new producer for it is issued in the same cycle.
        assign fwd   = wr_en && (bus.WADDR == raddr);
        assign rdata = is_zero ? '0 : (fwd ? bus.WDATA : mem_q[raddr]);
        assign rbusy = is_zero ? 1'b0
                     : (fwd ? (bus.ISSUE_VALID && (bus.ISSUE_RD == raddr)) : busy[raddr]);
`else
        assign rdata = is_zero ? '0 : mem_q[raddr];
        assign rbusy = is_zero ? 1'b0 : busy[raddr];
`endif

        assign bus.RDATA[i*XLEN +: XLEN] = rdata;
        assign bus.RBUSY[i]              = rbusy;
    end

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Self-checking bench for regfile_multiport_sb: directed scenarios followed by
// randomized traffic, all checked against an array-based reference model.
module tb_regfile_multiport_sb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned NREAD = 2;
    localparam int unsigned AW    = 5;

    logic CLK = 1'b0;
    logic RESET_N;

    always #5 CLK = ~CLK;

    regfile_multiport_sb_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD)) bus ();

    regfile_multiport_sb #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .NREAD (NREAD)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    // Reference model: architectural register values and the set of busy registers.
    logic [XLEN-1:0] m_mem  [DEPTH];
    bit              m_busy [DEPTH];

    int n_vec = 0;
    int n_err = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < DEPTH; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int r = 0; r < DEPTH; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    function automatic logic [XLEN-1:0] exp_rdata(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYPASS && bus.WE && bus.WADDR == a) return bus.WDATA;
        return m_mem[a];
    endfunction

    function automatic logic exp_rbusy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (BYPASS && bus.WE && bus.WADDR == a) return bus.ISSUE_VALID && bus.ISSUE_RD == a;
        return m_busy[a];
    endfunction

    // Architectural effect of one clock edge: writeback retires, then issue claims.
    function automatic void model_edge();
        if (bus.WE && bus.WADDR != 0) begin
            m_mem[bus.WADDR]  = bus.WDATA;
            m_busy[bus.WADDR] = 1'b0;
        end
        if (bus.ISSUE_VALID && bus.ISSUE_RD != 0) m_busy[bus.ISSUE_RD] = 1'b1;
    endfunction

    task automatic check_outputs(input string tag);
        logic [AW-1:0] a;
        for (int i = 0; i < NREAD; i++) begin
            a = bus.RADDR[i*AW +: AW];
            check_eq($sformatf("%s rdata%0d[x%0d]", tag, i, a),
                     64'(bus.RDATA[i*XLEN +: XLEN]), 64'(exp_rdata(a)));
            check_eq($sformatf("%s rbusy%0d[x%0d]", tag, i, a),
                     64'(bus.RBUSY[i]), 64'(exp_rbusy(a)));
        end
        check_eq({tag, " pending_cnt"}, 64'(bus.PENDING_CNT), 64'(model_cnt()));
    endtask

    // Inputs are set 1ns after a rising edge; check mid-cycle, then clock.
    task automatic cycle(input string tag);
        #2;
        check_outputs(tag);
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        bus.RADDR       = '0;
        bus.WE          = 1'b0;
        bus.WADDR       = '0;
        bus.WDATA       = '0;
        bus.ISSUE_VALID = 1'b0;
        bus.ISSUE_RD    = '0;
    endtask

    task automatic rand_raddr();
        for (int i = 0; i < NREAD; i++) begin
            if ($urandom_range(0, 3) == 0) bus.RADDR[i*AW +: AW] = bus.WADDR;
            else bus.RADDR[i*AW +: AW] = AW'($urandom_range(0, DEPTH-1));
        end
    endtask

    initial begin
        // 1: reset state, then reset asserted mid-cycle over live contents
        RESET_N = 1'b0;
        set_idle();
        model_reset();
        #2;
        check_outputs("reset");
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        bus.WE = 1'b1; bus.WADDR = 5; bus.WDATA = 32'hDEADBEEF;
        bus.ISSUE_VALID = 1'b1; bus.ISSUE_RD = 5;
        cycle("t1_wr");
        set_idle();
        bus.RADDR[0 +: AW] = 5;
        #1;
        check_eq("t1_pre_rdata", 64'(bus.RDATA[0 +: XLEN]), 64'h0000_0000_DEAD_BEEF);
        check_eq("t1_pre_cnt", 64'(bus.PENDING_CNT), 64'd1);
        #1;
        RESET_N = 1'b0;
        #1;
        check_eq("t1_rst_rdata", 64'(bus.RDATA[0 +: XLEN]), 64'd0);
        check_eq("t1_rst_cnt", 64'(bus.PENDING_CNT), 64'd0);
        check_eq("t1_rst_rbusy", 64'(bus.RBUSY), 64'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        cycle("t1_post");

        // 2: x0 is hardwired zero and never busy
        bus.WE = 1'b1; bus.WADDR = 0; bus.WDATA = 32'h1234;
        bus.ISSUE_VALID = 1'b1; bus.ISSUE_RD = 0;
        cycle("t2_x0");
        set_idle();
        #1;
        check_eq("t2_rdata0", 64'(bus.RDATA[0 +: XLEN]), 64'd0);
        check_eq("t2_rbusy", 64'(bus.RBUSY), 64'd0);
        check_eq("t2_cnt", 64'(bus.PENDING_CNT), 64'd0);
        cycle("t2_idle");

        // 3: issue then writeback of x7
        bus.ISSUE_VALID = 1'b1; bus.ISSUE_RD = 7;
        cycle("t3_issue");
        set_idle();
        bus.RADDR[0 +: AW] = 7;
        #1;
        check_eq("t3_busy", 64'(bus.RBUSY[0]), 64'd1);
        check_eq("t3_cnt1", 64'(bus.PENDING_CNT), 64'd1);
        bus.WE = 1'b1; bus.WADDR = 7; bus.WDATA = 32'h55;
        cycle("t3_wb");
        set_idle();
        bus.RADDR[0 +: AW] = 7;
        #1;
        check_eq("t3_rdata", 64'(bus.RDATA[0 +: XLEN]), 64'h55);
        check_eq("t3_idle", 64'(bus.RBUSY[0]), 64'd0);
        check_eq("t3_cnt0", 64'(bus.PENDING_CNT), 64'd0);
        cycle("t3_post");

        // 4: issue and writeback of x9 in the same cycle keeps it busy
        bus.ISSUE_VALID = 1'b1; bus.ISSUE_RD = 9;
        cycle("t4_issue");
        bus.ISSUE_VALID = 1'b1; bus.ISSUE_RD = 9;
        bus.WE = 1'b1; bus.WADDR = 9; bus.WDATA = 32'h9999_0009;
        cycle("t4_coll");
        set_idle();
        bus.RADDR[NREAD*AW-AW +: AW] = 9;
        #1;
        check_eq("t4_busy", 64'(bus.RBUSY[NREAD-1]), 64'd1);
        check_eq("t4_cnt", 64'(bus.PENDING_CNT), 64'd1);
        check_eq("t4_rdata", 64'(bus.RDATA[NREAD*XLEN-XLEN +: XLEN]), 64'h9999_0009);
        bus.WE = 1'b1; bus.WADDR = 9; bus.WDATA = 32'h9;
        cycle("t4_wb");

        // 5: same-cycle read of the register being written
        set_idle();
        bus.WE = 1'b1; bus.WADDR = 3; bus.WDATA = 32'h1111;
        cycle("t5_pre");
        bus.RADDR[0 +: AW] = 3; bus.WDATA = 32'hA5A5;
        #1;
        check_eq("t5_fwd", 64'(bus.RDATA[0 +: XLEN]), BYPASS ? 64'hA5A5 : 64'h1111);
        cycle("t5_wr");

        // 6: fill every register, then drain, with random read traffic
        for (int r = 1; r < DEPTH; r++) begin
            set_idle();
            bus.ISSUE_VALID = 1'b1; bus.ISSUE_RD = AW'(r);
            rand_raddr();
            cycle("t6_fill");
        end
        set_idle();
        #1;
        check_eq("t6_full", 64'(bus.PENDING_CNT), 64'(DEPTH-1));
        for (int r = 1; r < DEPTH; r++) begin
            set_idle();
            bus.WE = 1'b1; bus.WADDR = AW'(r); bus.WDATA = $urandom;
            rand_raddr();
            cycle("t6_drain");
        end
        set_idle();
        #1;
        check_eq("t6_empty", 64'(bus.PENDING_CNT), 64'd0);
        cycle("t6_post");

        // Random mixed traffic
        for (int n = 0; n < 400; n++) begin
            bus.ISSUE_VALID = 1'($urandom_range(0, 1));
            bus.ISSUE_RD    = AW'($urandom_range(0, DEPTH-1));
            bus.WE          = 1'($urandom_range(0, 1));
            bus.WADDR       = ($urandom_range(0, 2) == 0) ? bus.ISSUE_RD
                                                          : AW'($urandom_range(0, DEPTH-1));
            bus.WDATA       = $urandom;
            rand_raddr();
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
